// File: rtl/spinnaker_fpgas_spi_slave.sv
// SPI mode-0 slave for peek/poke: oversampled SCLK/NSS/MOSI to parallel address, read and write strobes.
// Read strobe 1 cycle after the last address bit; write strobe 1 cycle after the last data bit; no backpressure.
module spinnaker_fpgas_spi_slave #(
    parameter int SPI_ADDR_BITS = 32,
    parameter int VAL_BITS      = 32,
    parameter int CMD_BITS      = 8
) (
    input  logic                     CLK_IN,
    input  logic                     RESET_IN,
    input  logic                     SPI_SCLK_IN,
    input  logic                     SPI_NSS_IN,
    input  logic                     SPI_MOSI_IN,
    output logic                     SPI_MISO_OUT,
    output logic [SPI_ADDR_BITS-1:0] SPI_ADDR_OUT,
    output logic                     SPI_READ_OUT,
    output logic                     SPI_WRITE_OUT,
    output logic [VAL_BITS-1:0]      SPI_WRITE_DATA_OUT,
    input  logic [VAL_BITS-1:0]      SPI_READ_VALUE_IN
);

    localparam int RX_BITS  = (SPI_ADDR_BITS > VAL_BITS) ? SPI_ADDR_BITS : VAL_BITS;
    localparam int CNT_BITS = $clog2(RX_BITS + 1);
    localparam logic [CMD_BITS-1:0] CMD_WRITE = CMD_BITS'(1);
    localparam logic [CMD_BITS-1:0] CMD_READ  = CMD_BITS'(2);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, RSTB, DATA, DONE} state_t;

    state_t                state, state_next;
    logic                  sclk_s1, sclk_s2, sclk_s3;
    logic                  nss_s1, nss_s2;
    logic                  mosi_s1, mosi_s2;
    logic                  sclk_rise, sclk_fall;
    logic [CNT_BITS-1:0]   cnt;
    logic [RX_BITS-1:0]    rx_sr, rx_next;
    logic [VAL_BITS-1:0]   tx_sr;
    logic                  miso_q;
    logic                  is_read;
    logic                  cmd_last, addr_last, data_last;
    logic                  cmd_done, addr_done, data_done, cmd_valid, phase_last, shifting;

    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            nss_s1  <= 1'b1;
            nss_s2  <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= SPI_SCLK_IN;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            nss_s1  <= SPI_NSS_IN;
            nss_s2  <= nss_s1;
            mosi_s1 <= SPI_MOSI_IN;
            mosi_s2 <= mosi_s1;
        end
    end

    always_comb begin
        sclk_rise  = sclk_s2 & ~sclk_s3;
        sclk_fall  = ~sclk_s2 & sclk_s3;
        rx_next    = {rx_sr[RX_BITS-2:0], mosi_s2};
        cmd_last   = (cnt == CNT_BITS'(CMD_BITS - 1));
        addr_last  = (cnt == CNT_BITS'(SPI_ADDR_BITS - 1));
        data_last  = (cnt == CNT_BITS'(VAL_BITS - 1));
        cmd_valid  = (rx_next[CMD_BITS-1:0] == CMD_WRITE) || (rx_next[CMD_BITS-1:0] == CMD_READ);
        shifting   = sclk_rise && (state == CMD || state == ADDR || state == DATA);
        phase_last = (state == CMD && cmd_last) || (state == ADDR && addr_last) ||
                     (state == DATA && data_last);
        // An abort beats the last command/address bit, but the final data bit is accepted first.
        cmd_done   = (state == CMD)  && sclk_rise && cmd_last  && !nss_s2;
        addr_done  = (state == ADDR) && sclk_rise && addr_last && !nss_s2;
        data_done  = (state == DATA) && sclk_rise && data_last;
    end

    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) state <= IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (!nss_s2) state_next = CMD;
            CMD: begin
                if (nss_s2)        state_next = IDLE;
                else if (cmd_done) state_next = cmd_valid ? ADDR : DONE;
            end
            ADDR: begin
                if (nss_s2)         state_next = IDLE;
                else if (addr_done) state_next = is_read ? RSTB : DATA;
            end
            RSTB: state_next = nss_s2 ? IDLE : DATA;
            DATA: begin
                if (data_done)   state_next = nss_s2 ? IDLE : DONE;
                else if (nss_s2) state_next = IDLE;
            end
            DONE: if (nss_s2) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        SPI_READ_OUT = (state == RSTB);
        SPI_MISO_OUT = (state == DATA && is_read) ? miso_q : 1'b0;
    end

    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            cnt                <= '0;
            rx_sr              <= '0;
            tx_sr              <= '0;
            miso_q             <= 1'b0;
            is_read            <= 1'b0;
            SPI_ADDR_OUT       <= '0;
            SPI_WRITE_DATA_OUT <= '0;
            SPI_WRITE_OUT      <= 1'b0;
        end else begin
            SPI_WRITE_OUT <= data_done && !is_read;
            if (shifting) begin
                rx_sr <= rx_next;
                cnt   <= phase_last ? '0 : cnt + CNT_BITS'(1);
            end
            if (state == IDLE) begin
                cnt    <= '0;
                miso_q <= 1'b0;
            end
            if (cmd_done)
                is_read <= (rx_next[CMD_BITS-1:0] == CMD_READ);
            if (addr_done)
                SPI_ADDR_OUT <= rx_next[SPI_ADDR_BITS-1:0];
            if (data_done && !is_read)
                SPI_WRITE_DATA_OUT <= rx_next[VAL_BITS-1:0];
            if (state == RSTB)
                tx_sr <= SPI_READ_VALUE_IN;
            if (state == DATA && is_read && sclk_fall) begin
                miso_q <= tx_sr[VAL_BITS-1];
                tx_sr  <= {tx_sr[VAL_BITS-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_spinnaker_fpgas_spi_slave.sv
// Directed bench for the SPI slave: write, read, invalid, abort, reset and back-to-back frames at SCLK = CLK/8.
module tb_spinnaker_fpgas_spi_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        nss = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [31:0] addr_out;
    logic        rd_stb;
    logic        wr_stb;
    logic [31:0] wdata_out;
    logic [31:0] rd_in;
    logic [31:0] rd_val = 32'h0;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          rise_count = 0;
    int          rd_rise = 0;
    logic [31:0] wr_addr = 32'h0;
    logic [31:0] wr_data = 32'h0;
    logic [71:0] rx;
    int          wr0, rd0;

    always #5 clk = ~clk;

    // The decoder value is only meaningful during the strobe; garbage elsewhere exposes a mistimed capture.
    assign rd_in = rd_stb ? rd_val : 32'hFFFF_FFFF;

    spinnaker_fpgas_spi_slave dut (
        .CLK_IN             (clk),
        .RESET_IN           (rst_n),
        .SPI_SCLK_IN        (sclk),
        .SPI_NSS_IN         (nss),
        .SPI_MOSI_IN        (mosi),
        .SPI_MISO_OUT       (miso),
        .SPI_ADDR_OUT       (addr_out),
        .SPI_READ_OUT       (rd_stb),
        .SPI_WRITE_OUT      (wr_stb),
        .SPI_WRITE_DATA_OUT (wdata_out),
        .SPI_READ_VALUE_IN  (rd_in)
    );

    always @(negedge clk) begin
        if (wr_stb) begin
            wr_cnt++;
            wr_addr = addr_out;
            wr_data = wdata_out;
        end
        if (rd_stb) begin
            rd_cnt++;
            rd_rise = rise_count;
        end
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends the first nbits of {cmd, addr, data}; MISO is sampled just before each SCLK rise.
    task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                             input int nbits, input bit nss_with_last, input bit keep_nss,
                             input int gap, output logic [71:0] rx_bits);
        logic [71:0] tx;
        tx = {cmd, addr, data};
        rx_bits = '0;
        rise_count = 0;
        nss = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[71-i];
            repeat (4) @(negedge clk);
            rx_bits[71-i] = miso;
            sclk = 1'b1;
            rise_count++;
            if (nss_with_last && i == nbits - 1) nss = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        mosi = 1'b0;
        if (!keep_nss) begin
            nss = 1'b1;
            repeat (gap) @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_addr", addr_out, 0);
        check("rst_wdata", wdata_out, 0);
        check("rst_read", rd_stb, 0);
        check("rst_write", wr_stb, 0);
        check("rst_miso", miso, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Plain write
        wr0 = wr_cnt; rd0 = rd_cnt;
        spi_frame(8'h01, 32'h0002_0010, 32'hDEAD_BEEF, 72, 1'b0, 1'b0, 10, rx);
        check("w1_strobes", wr_cnt - wr0, 1);
        check("w1_no_read", rd_cnt - rd0, 0);
        check("w1_addr", addr_out, 32'h0002_0010);
        check("w1_wdata", wdata_out, 32'hDEAD_BEEF);
        check("w1_stb_addr", wr_addr, 32'h0002_0010);
        check("w1_stb_data", wr_data, 32'hDEAD_BEEF);
        check("w1_miso", rx, 0);

        // Plain read
        wr0 = wr_cnt; rd0 = rd_cnt; rd_val = 32'hA5A5_0F0F;
        spi_frame(8'h02, 32'h0003_0004, 32'h0, 72, 1'b0, 1'b0, 10, rx);
        check("r1_strobes", rd_cnt - rd0, 1);
        check("r1_no_write", wr_cnt - wr0, 0);
        check("r1_rise", rd_rise, 40);
        check("r1_data", rx[31:0], 32'hA5A5_0F0F);
        check("r1_miso_pre", rx[71:32], 0);
        check("r1_miso_post", miso, 0);
        check("r1_addr", addr_out, 32'h0003_0004);

        // Invalid command, then a valid write
        wr0 = wr_cnt; rd0 = rd_cnt;
        spi_frame(8'h7F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 72, 1'b0, 1'b0, 10, rx);
        check("inv_strobes", (wr_cnt - wr0) + (rd_cnt - rd0), 0);
        check("inv_miso", rx, 0);
        check("inv_addr", addr_out, 32'h0003_0004);
        spi_frame(8'h01, 32'h0005_0020, 32'h0BAD_F00D, 72, 1'b0, 1'b0, 10, rx);
        check("inv_w_strobes", wr_cnt - wr0, 1);
        check("inv_w_addr", addr_out, 32'h0005_0020);
        check("inv_w_wdata", wdata_out, 32'h0BAD_F00D);

        // Write aborted after 20 data bits, then a read
        wr0 = wr_cnt; rd0 = rd_cnt;
        spi_frame(8'h01, 32'h0006_0000, 32'h1122_3344, 60, 1'b0, 1'b0, 10, rx);
        check("abt_strobes", wr_cnt - wr0, 0);
        check("abt_wdata", wdata_out, 32'h0BAD_F00D);
        rd_val = 32'h3C96_5A01;
        spi_frame(8'h02, 32'h0004_0000, 32'h0, 72, 1'b0, 1'b0, 10, rx);
        check("abt_r_strobes", rd_cnt - rd0, 1);
        check("abt_r_data", rx[31:0], 32'h3C96_5A01);
        check("abt_r_addr", addr_out, 32'h0004_0000);

        // Reset in the middle of the address field
        spi_frame(8'h01, 32'h0007_0000, 32'h0, 24, 1'b0, 1'b1, 0, rx);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_addr", addr_out, 0);
        check("mid_rst_wdata", wdata_out, 0);
        check("mid_rst_strobes", {rd_stb, wr_stb, miso}, 0);
        nss = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_addr", addr_out, 0);
        check("post_rst_wdata", wdata_out, 0);
        wr0 = wr_cnt;
        spi_frame(8'h01, 32'h0001_0008, 32'h1234_5678, 72, 1'b0, 1'b0, 10, rx);
        check("rst_w_strobes", wr_cnt - wr0, 1);
        check("rst_w_addr", wr_addr, 32'h0001_0008);
        check("rst_w_data", wr_data, 32'h1234_5678);

        // Back-to-back frames with a 3-cycle NSS gap
        wr0 = wr_cnt; rd0 = rd_cnt; rd_val = 32'h5A5A_C3C3;
        spi_frame(8'h01, 32'h0008_0004, 32'hCAFE_F00D, 72, 1'b0, 1'b0, 3, rx);
        spi_frame(8'h02, 32'h0009_0008, 32'h0, 72, 1'b0, 1'b0, 10, rx);
        check("b2b_wr", wr_cnt - wr0, 1);
        check("b2b_rd", rd_cnt - rd0, 1);
        check("b2b_w_data", wr_data, 32'hCAFE_F00D);
        check("b2b_r_data", rx[31:0], 32'h5A5A_C3C3);
        check("b2b_addr", addr_out, 32'h0009_0008);

        // NSS rises together with the final data bit: the write still happens
        wr0 = wr_cnt;
        spi_frame(8'h01, 32'h000A_0000, 32'h8765_4321, 72, 1'b1, 1'b0, 10, rx);
        check("sim_wr", wr_cnt - wr0, 1);
        check("sim_wdata", wdata_out, 32'h8765_4321);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
